// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: special and general registers, a priority bus mux and a small ALU.
// An external sequencer drives every load/drive strobe one cycle at a time.
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R4out,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             AND,
    input  logic             R5in,
    input  logic             R2in,
    input  logic             R4in,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] PC_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] MDR_q,
    output logic [WIDTH-1:0] Y_q,
    output logic [WIDTH-1:0] Z_q,
    output logic [WIDTH-1:0] R2_q,
    output logic [WIDTH-1:0] R4_q,
    output logic [WIDTH-1:0] R5_q
);

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_PC,
        SRC_Z,
        SRC_MDR,
        SRC_R2,
        SRC_R4
    } bus_src_e;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_AND,
        ALU_INC
    } alu_op_e;

    logic [WIDTH-1:0] pc_q,  pc_d;
    logic [WIDTH-1:0] ir_q,  ir_d;
    logic [WIDTH-1:0] mar_q, mar_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] y_q,   y_d;
    logic [WIDTH-1:0] z_q,   z_d;
    logic [WIDTH-1:0] r2_q,  r2_d;
    logic [WIDTH-1:0] r4_q,  r4_d;
    logic [WIDTH-1:0] r5_q,  r5_d;

    bus_src_e         bus_src;
    alu_op_e          alu_op;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] mdr_in;

    // Several drivers at once is legal; the earliest strobe in this chain owns the bus.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        bus_src = SRC_NONE;
        if (PCout)        bus_src = SRC_PC;
        else if (Zlowout) bus_src = SRC_Z;
        else if (MDRout)  bus_src = SRC_MDR;
        else if (R2out)   bus_src = SRC_R2;
        else if (R4out)   bus_src = SRC_R4;
    end

    always_comb begin
        bus = '0;
        case (bus_src)
            SRC_PC:  bus = pc_q;
            SRC_Z:   bus = z_q;
            SRC_MDR: bus = mdr_q;
            SRC_R2:  bus = r2_q;
            SRC_R4:  bus = r4_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        alu_op = ALU_PASS;
        if (IncPC)    alu_op = ALU_INC;
        else if (AND) alu_op = ALU_AND;
    end

    always_comb begin
        alu_result = bus;
        case (alu_op)
            ALU_INC:  alu_result = bus + WIDTH'(1);
            ALU_AND:  alu_result = y_q & bus;
            default:  alu_result = bus;
        endcase
    end

    assign mdr_in = Read ? Mdatain : bus;

    // Registers only ever read the bus built from their pre-edge values, so out+in of one register holds.
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        mar_d = mar_q;
        mdr_d = mdr_q;
        y_d   = y_q;
        z_d   = z_q;
        r2_d  = r2_q;
        r4_d  = r4_q;
        r5_d  = r5_q;
        if (PCin)  pc_d  = bus;
        if (IRin)  ir_d  = bus;
        if (MARin) mar_d = bus;
        if (MDRin) mdr_d = mdr_in;
        if (Yin)   y_d   = bus;
        if (Zin)   z_d   = alu_result;
        if (R2in)  r2_d  = bus;
        if (R4in)  r4_d  = bus;
        if (R5in)  r5_d  = bus;
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking updates so every register samples pre-edge values; the synchronous
        // clear is checked first so it overrides any load strobe in the same cycle.
        if (!Clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
            r2_q  <= '0;
            r4_q  <= '0;
            r5_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
            r2_q  <= r2_d;
            r4_q  <= r4_d;
            r5_q  <= r5_d;
        end
    end

    assign BusMuxOut = bus;
    assign PC_q      = pc_q;
    assign IR_q      = ir_q;
    assign MAR_q     = mar_q;
    assign MDR_q     = mdr_q;
    assign Y_q       = y_q;
    assign Z_q       = z_q;
    assign R2_q      = r2_q;
    assign R4_q      = r4_q;
    assign R5_q      = r5_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed micro-op sequences plus randomized strobes against an array-based model.
module tb_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic Clear, PCout, Zlowout, MDRout, R2out, R4out;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, AND, R5in, R2in, R4in;
    logic [31:0] Mdatain, BusMuxOut;
    logic [31:0] MAR_q, PC_q, IR_q, MDR_q, Y_q, Z_q, R2_q, R4_q, R5_q;

    datapath #(.WIDTH(32)) dut (
        .Clock(clk), .Clear(Clear),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R4out(R4out),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .AND(AND), .R5in(R5in), .R2in(R2in), .R4in(R4in),
        .Mdatain(Mdatain), .BusMuxOut(BusMuxOut),
        .MAR_q(MAR_q), .PC_q(PC_q), .IR_q(IR_q), .MDR_q(MDR_q), .Y_q(Y_q), .Z_q(Z_q),
        .R2_q(R2_q), .R4_q(R4_q), .R5_q(R5_q)
    );

    int checks = 0;
    int errors = 0;

    localparam int PC = 0, IR = 1, MAR = 2, MDR = 3, Y = 4, Z = 5, R2 = 6, R4 = 7, R5 = 8;
    string       names [9] = '{"PC", "IR", "MAR", "MDR", "Y", "Z", "R2", "R4", "R5"};
    logic [31:0] m [9];

    function automatic logic [31:0] dut_reg(input int i);
        case (i)
            PC:      return PC_q;
            IR:      return IR_q;
            MAR:     return MAR_q;
            MDR:     return MDR_q;
            Y:       return Y_q;
            Z:       return Z_q;
            R2:      return R2_q;
            R4:      return R4_q;
            default: return R5_q;
        endcase
    endfunction

    // Walk drivers from lowest to highest priority; the last one asserted wins.
    function automatic logic [31:0] model_bus();
        logic [31:0] v;
        v = 32'h0;
        if (R4out)   v = m[R4];
        if (R2out)   v = m[R2];
        if (MDRout)  v = m[MDR];
        if (Zlowout) v = m[Z];
        if (PCout)   v = m[PC];
        return v;
    endfunction

    task automatic clear_strobes();
        Clear = 1'b1;
        {PCout, Zlowout, MDRout, R2out, R4out} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, AND, R5in, R2in, R4in} = '0;
        Mdatain = 32'h0;
    endtask

    // Advance one rising edge, updating the model from the strobes present at that edge.
    task automatic tick();
        logic [31:0] b, r;
        logic [31:0] nxt [9];
        b = model_bus();
        r = IncPC ? b + 32'd1 : (AND ? (m[Y] & b) : b);
        nxt = m;
        if (!Clear) begin
            foreach (nxt[i]) nxt[i] = 32'h0;
        end else begin
            if (PCin)  nxt[PC]  = b;
            if (IRin)  nxt[IR]  = b;
            if (MARin) nxt[MAR] = b;
            if (MDRin) nxt[MDR] = Read ? Mdatain : b;
            if (Yin)   nxt[Y]   = b;
            if (Zin)   nxt[Z]   = r;
            if (R2in)  nxt[R2]  = b;
            if (R4in)  nxt[R4]  = b;
            if (R5in)  nxt[R5]  = b;
        end
        @(posedge clk);
        m = nxt;
        #1;
        clear_strobes();
    endtask

    task automatic test_reset();
        clear_strobes();
        Clear = 1'b0;
        tick();
        Mdatain = 32'hDEAD_BEEF; Read = 1'b1; MDRin = 1'b1;
        tick();
        MDRout = 1'b1;
        {PCin, IRin, MARin, Yin, Zin, R2in, R4in, R5in} = '1;
        tick();
        checks++;
        if (PC_q !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL reset_preload: PC got %h want %h", PC_q, 32'hDEAD_BEEF);
        end
        Clear = 1'b0; MDRout = 1'b1;
        {PCin, IRin, MARin, Yin, Zin, R2in, R4in, R5in, MDRin} = '1;
        tick();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (dut_reg(i) !== 32'h0) begin
                errors++; $display("FAIL reset_%s: got %h want 0", names[i], dut_reg(i));
            end
        end
        #1;
        checks++;
        if (BusMuxOut !== 32'h0) begin
            errors++; $display("FAIL reset_bus_idle: got %h want 0", BusMuxOut);
        end
    endtask

    task automatic test_mdr_loads();
        logic [31:0] vals [3] = '{32'h22, 32'h24, 32'h26};
        for (int k = 0; k < 3; k++) begin
            Mdatain = vals[k]; Read = 1'b1; MDRin = 1'b1;
            tick();
            checks++;
            if (MDR_q !== vals[k]) begin
                errors++; $display("FAIL mdr_load_%0d: got %h want %h", k, MDR_q, vals[k]);
            end
            MDRout = 1'b1;
            if (k == 0) R2in = 1'b1; else if (k == 1) R4in = 1'b1; else R5in = 1'b1;
            tick();
            checks++;
            if (dut_reg(R2 + k) !== vals[k]) begin
                errors++; $display("FAIL reg_load_%s: got %h want %h", names[R2 + k], dut_reg(R2 + k), vals[k]);
            end
        end
        Mdatain = 32'h1234_5678; Read = 1'b1;
        tick();
        checks++;
        if (MDR_q !== 32'h26) begin
            errors++; $display("FAIL read_without_mdrin: got %h want %h", MDR_q, 32'h26);
        end
    endtask

    task automatic test_fetch();
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        tick();
        checks += 2;
        if (MAR_q !== 32'h0) begin errors++; $display("FAIL fetch_t0_mar: got %h want 0", MAR_q); end
        if (Z_q !== 32'h1)   begin errors++; $display("FAIL fetch_t0_z: got %h want 1", Z_q); end
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h4A92_0000;
        tick();
        checks += 2;
        if (PC_q !== 32'h1) begin errors++; $display("FAIL fetch_t1_pc: got %h want 1", PC_q); end
        if (MDR_q !== 32'h4A92_0000) begin
            errors++; $display("FAIL fetch_t1_mdr: got %h want %h", MDR_q, 32'h4A92_0000);
        end
        MDRout = 1'b1; IRin = 1'b1;
        tick();
        checks++;
        if (IR_q !== 32'h4A92_0000) begin
            errors++; $display("FAIL fetch_t2_ir: got %h want %h", IR_q, 32'h4A92_0000);
        end
    endtask

    task automatic test_and();
        R2out = 1'b1; Yin = 1'b1;
        tick();
        checks++;
        if (Y_q !== 32'h22) begin errors++; $display("FAIL and_t3_y: got %h want 22", Y_q); end
        R4out = 1'b1; AND = 1'b1; Zin = 1'b1;
        tick();
        checks++;
        if (Z_q !== 32'h20) begin errors++; $display("FAIL and_t4_z: got %h want 20", Z_q); end
        Zlowout = 1'b1; R5in = 1'b1;
        tick();
        checks++;
        if (R5_q !== 32'h20) begin errors++; $display("FAIL and_t5_r5: got %h want 20", R5_q); end
    endtask

    task automatic test_priority();
        PCout = 1'b1; R2out = 1'b1;
        #1;
        checks++;
        if (BusMuxOut !== 32'h1) begin
            errors++; $display("FAIL bus_priority_pc_r2: got %h want 1", BusMuxOut);
        end
        clear_strobes();
        R4out = 1'b1; IncPC = 1'b1; AND = 1'b1; Zin = 1'b1;
        tick();
        checks++;
        if (Z_q !== 32'h25) begin errors++; $display("FAIL alu_priority_inc: got %h want 25", Z_q); end
        R2out = 1'b1; R2in = 1'b1;
        tick();
        checks++;
        if (R2_q !== 32'h22) begin errors++; $display("FAIL same_reg_out_in: got %h want 22", R2_q); end
    endtask

    task automatic test_wrap();
        Mdatain = 32'hFFFF_FFFF; Read = 1'b1; MDRin = 1'b1;
        tick();
        MDRout = 1'b1; PCin = 1'b1;
        tick();
        PCout = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        tick();
        checks++;
        if (Z_q !== 32'h0) begin errors++; $display("FAIL incpc_wrap: got %h want 0", Z_q); end
    endtask

    task automatic test_mid_reset();
        R2out = 1'b1; Yin = 1'b1;
        tick();
        Clear = 1'b0; R4out = 1'b1; AND = 1'b1; Zin = 1'b1; Yin = 1'b1;
        tick();
        checks += 2;
        if (Z_q !== 32'h0) begin errors++; $display("FAIL mid_reset_z: got %h want 0", Z_q); end
        if (Y_q !== 32'h0) begin errors++; $display("FAIL mid_reset_y: got %h want 0", Y_q); end
    endtask

    task automatic test_random();
        logic [31:0] exp_bus;
        for (int n = 0; n < 300; n++) begin
            Clear   = ($urandom_range(0, 19) != 0);
            PCout   = ($urandom_range(0, 3) == 0);
            Zlowout = ($urandom_range(0, 3) == 0);
            MDRout  = ($urandom_range(0, 3) == 0);
            R2out   = ($urandom_range(0, 3) == 0);
            R4out   = ($urandom_range(0, 3) == 0);
            {MARin, Zin, PCin, MDRin, IRin, Yin} = 6'($urandom);
            {IncPC, Read, AND, R5in, R2in, R4in} = 6'($urandom);
            Mdatain = (n % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            #1;
            exp_bus = model_bus();
            checks++;
            if (BusMuxOut !== exp_bus) begin
                errors++; $display("FAIL rand_bus[%0d]: got %h want %h", n, BusMuxOut, exp_bus);
            end
            tick();
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (dut_reg(i) !== m[i]) begin
                    errors++; $display("FAIL rand_%s[%0d]: got %h want %h", names[i], n, dut_reg(i), m[i]);
                end
            end
        end
    endtask

    initial begin
        clear_strobes();
        @(posedge clk);
        #1;
        test_reset();
        test_mdr_loads();
        test_fetch();
        test_and();
        test_priority();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
